mac_qmgr: RTL and testbench

MAC_QMGR -- requirements
Module: mac_qmgr

---
 rtl/mac_qmgr.sv | 181 ++++++++++++++++++
 tb/tb_mac_qmgr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_qmgr.sv
// rtl/mac_qmgr.sv - descriptor queue occupancy manager with register block; MAC_QMGR_IRQ_EN adds thresholds, IMASK and irq
module mac_qmgr #(
    parameter int NCH = 2,
    parameter int QDW = 4,
    parameter int ADW = 10
) (
    input  logic                 app_clk,
    input  logic                 reset_n,
    input  logic                 reg_cs,
    input  logic                 reg_wr,
    input  logic [3:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    input  logic [3:0]           reg_be,
    output logic [31:0]          reg_rdata,
    output logic                 reg_ack,
    input  logic [NCH-1:0]       qcnt_inc,
    input  logic [NCH-1:0]       qcnt_dec,
    output logic [NCH*ADW-1:0]   qbase_addr,
    output logic [NCH*QDW-1:0]   qcnt,
    output logic [NCH-1:0]       q_empty,
    output logic [NCH-1:0]       q_full,
    output logic                 irq
);

    localparam logic [QDW-1:0] CNT_MAX = '1;

    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [NCH-1:0]   r_en;
    logic [NCH-1:0]   r_ovf;
    logic [NCH-1:0]   r_unf;
    logic [QDW-1:0]   r_cnt  [NCH];
    logic [ADW-1:0]   r_base [NCH];
`ifdef MAC_QMGR_IRQ_EN
    logic [QDW-1:0]   r_thr  [NCH];
    logic [1:0]       r_imask;
    logic             r_irq;
    logic [NCH-1:0]   w_hit;
    logic [QDW-1:0]   w_thr_new [NCH];
`endif

    logic             w_acc;
    logic             w_wr;
    logic [31:0]      w_bmask;
    logic [31:0]      w_rmux;
    logic [NCH-1:0]   w_en_nxt;
    logic [NCH-1:0]   w_ovf_clr;
    logic [NCH-1:0]   w_unf_clr;
    logic [NCH-1:0]   w_ovf_set;
    logic [NCH-1:0]   w_unf_set;
    logic [NCH-1:0]   w_wr_qcfg;
    logic [QDW-1:0]   w_cnt_nxt  [NCH];
    logic [ADW-1:0]   w_base_new [NCH];
    logic             w_unused;

    // An access is taken only when ack is low, so held strobes complete every second cycle
    assign w_acc   = reg_cs & ~r_ack;
    assign w_wr    = w_acc & reg_wr;
    assign w_bmask = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};

    assign w_en_nxt  = (w_wr && reg_addr == 4'h0 && reg_be[0]) ? reg_wdata[NCH-1:0] : r_en;
    assign w_ovf_clr = (w_wr && reg_addr == 4'h1 && reg_be[0]) ? reg_wdata[NCH-1:0] : '0;
    assign w_unf_clr = (w_wr && reg_addr == 4'h1 && reg_be[1]) ? reg_wdata[8 +: NCH] : '0;

    assign w_unused = &{1'b0, reg_wdata, reg_be};

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_wr_qcfg[c]  = w_wr && (reg_addr == 4'(2 + c));
            w_base_new[c] = (r_base[c] & ~w_bmask[ADW-1:0]) | (reg_wdata[ADW-1:0] & w_bmask[ADW-1:0]);
`ifdef MAC_QMGR_IRQ_EN
            w_thr_new[c]  = (r_thr[c] & ~w_bmask[16 +: QDW]) | (reg_wdata[16 +: QDW] & w_bmask[16 +: QDW]);
`endif
        end
    end

    // Flags follow the enable in force before this edge; a disable on this edge zeroes the count
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_cnt_nxt[c] = r_cnt[c];
            w_ovf_set[c] = 1'b0;
            w_unf_set[c] = 1'b0;
            if (r_en[c]) begin
                if (qcnt_inc[c] && !qcnt_dec[c]) begin
                    if (r_cnt[c] == CNT_MAX) w_ovf_set[c] = 1'b1;
                    else                     w_cnt_nxt[c] = r_cnt[c] + 1'b1;
                end else if (qcnt_dec[c] && !qcnt_inc[c]) begin
                    if (r_cnt[c] == '0) w_unf_set[c] = 1'b1;
                    else                w_cnt_nxt[c] = r_cnt[c] - 1'b1;
                end
            end
            if (!w_en_nxt[c]) w_cnt_nxt[c] = '0;
        end
    end

    always_comb begin
        w_rmux = '0;
        if (reg_addr == 4'h0) w_rmux[NCH-1:0] = r_en;
        if (reg_addr == 4'h1) begin
            w_rmux[NCH-1:0]  = r_ovf;
            w_rmux[8 +: NCH] = r_unf;
        end
`ifdef MAC_QMGR_IRQ_EN
        if (reg_addr == 4'hA) w_rmux[1:0] = r_imask;
`endif
        for (int c = 0; c < NCH; c++) begin
            if (reg_addr == 4'(2 + c)) begin
                w_rmux[ADW-1:0] = r_base[c];
`ifdef MAC_QMGR_IRQ_EN
                w_rmux[16 +: QDW] = r_thr[c];
`endif
            end
            if (reg_addr == 4'(6 + c)) w_rmux[QDW-1:0] = r_cnt[c];
        end
    end

`ifdef MAC_QMGR_IRQ_EN
    always_comb begin
        for (int c = 0; c < NCH; c++)
            w_hit[c] = r_en[c] && (r_thr[c] != '0) && (r_cnt[c] >= r_thr[c]);
    end
`endif

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_en    <= '0;
            r_ovf   <= '0;
            r_unf   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c]  <= '0;
                r_base[c] <= '0;
`ifdef MAC_QMGR_IRQ_EN
                r_thr[c]  <= '0;
`endif
            end
`ifdef MAC_QMGR_IRQ_EN
            r_imask <= '0;
            r_irq   <= 1'b0;
`endif
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_rdata <= reg_wr ? 32'h0 : w_rmux;
            r_en  <= w_en_nxt;
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
            r_unf <= (r_unf & ~w_unf_clr) | w_unf_set;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c] <= w_cnt_nxt[c];
                if (w_wr_qcfg[c]) begin
                    r_base[c] <= w_base_new[c];
`ifdef MAC_QMGR_IRQ_EN
                    r_thr[c]  <= w_thr_new[c];
`endif
                end
            end
`ifdef MAC_QMGR_IRQ_EN
            if (w_wr && reg_addr == 4'hA && reg_be[0]) r_imask <= reg_wdata[1:0];
            r_irq <= (r_imask[0] & (|w_hit)) | (r_imask[1] & ((|r_ovf) | (|r_unf)));
`endif
        end
    end

    assign reg_ack   = r_ack;
    assign reg_rdata = r_rdata;
`ifdef MAC_QMGR_IRQ_EN
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            qbase_addr[c*ADW +: ADW] = r_base[c];
            qcnt[c*QDW +: QDW]       = r_cnt[c];
            q_empty[c]               = (r_cnt[c] == '0);
            q_full[c]                = (r_cnt[c] == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_mac_qmgr.sv
// tb/tb_mac_qmgr.sv - self-checking bench for mac_qmgr (default build or MAC_QMGR_IRQ_EN)
module tb_mac_qmgr;

    localparam int NCH = 2;
    localparam int QDW = 4;
    localparam int ADW = 10;
`ifdef MAC_QMGR_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic               app_clk;
    logic               reset_n;
    logic               reg_cs;
    logic               reg_wr;
    logic [3:0]         reg_addr;
    logic [31:0]        reg_wdata;
    logic [3:0]         reg_be;
    logic [31:0]        reg_rdata;
    logic               reg_ack;
    logic [NCH-1:0]     qcnt_inc;
    logic [NCH-1:0]     qcnt_dec;
    logic [NCH*ADW-1:0] qbase_addr;
    logic [NCH*QDW-1:0] qcnt;
    logic [NCH-1:0]     q_empty;
    logic [NCH-1:0]     q_full;
    logic               irq;

    mac_qmgr #(.NCH(NCH), .QDW(QDW), .ADW(ADW)) dut (
        .app_clk(app_clk), .reset_n(reset_n),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .qcnt_inc(qcnt_inc), .qcnt_dec(qcnt_dec),
        .qbase_addr(qbase_addr), .qcnt(qcnt),
        .q_empty(q_empty), .q_full(q_full), .irq(irq)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    vec_t        vecs[$];
    logic [31:0] rd;

    function automatic vec_t mk(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] e, input string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.wd = wd; v.be = be; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic reg_access(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] data);
        int n;
        @(negedge app_clk);
        reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
        @(negedge app_clk);
        n = 0;
        while (!reg_ack && n < 4) begin
            @(negedge app_clk);
            n++;
        end
        chk("ack_seen", {31'b0, reg_ack}, 32'h1);
        data   = reg_rdata;
        reg_cs = 1'b0;
        @(negedge app_clk);
        chk("ack_one_cycle", {31'b0, reg_ack}, 32'h0);
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        reg_access(1'b0, addr, 32'h0, 4'h0, d);
        chk(name_q.pop_front(), d, exp_q.pop_front());
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] d;
        reg_access(1'b1, addr, wd, be, d);
    endtask

    task automatic pulse(input logic [NCH-1:0] inc, input logic [NCH-1:0] dec);
        @(negedge app_clk);
        qcnt_inc = inc; qcnt_dec = dec;
        @(negedge app_clk);
        qcnt_inc = '0; qcnt_dec = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},     {31'b0, reg_ack}, 32'h0);
        chk({tag, "_rdata"},   reg_rdata, 32'h0);
        chk({tag, "_qcnt"},    32'(qcnt), 32'h0);
        chk({tag, "_qempty"},  32'(q_empty), 32'h3);
        chk({tag, "_qfull"},   32'(q_full), 32'h0);
        chk({tag, "_qbase"},   32'(qbase_addr), 32'h0);
        chk({tag, "_irq"},     {31'b0, irq}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0;
        reg_wdata = '0; reg_be = '0; qcnt_inc = '0; qcnt_dec = '0;

        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h0, "ctrl_rst"));
        vecs.push_back(mk(0, 4'h1, 0, 0, 32'h0, "stat_rst"));
        vecs.push_back(mk(0, 4'h6, 0, 0, 32'h0, "qcnt0_rst"));
        vecs.push_back(mk(0, 4'h2, 0, 0, 32'h0, "qcfg0_rst"));
        vecs.push_back(mk(1, 4'h3, 32'h0000_03A5, 4'b0001, 0, ""));
        vecs.push_back(mk(0, 4'h3, 0, 0, 32'h0000_00A5, "qcfg1_be0"));
        vecs.push_back(mk(1, 4'h2, 32'h0004_0155, 4'hF, 0, ""));
        vecs.push_back(mk(0, 4'h2, 0, 0, IRQ ? 32'h0004_0155 : 32'h0000_0155, "qcfg0_full"));
        vecs.push_back(mk(1, 4'h2, 32'h000F_FF00, 4'h0, 0, ""));
        vecs.push_back(mk(0, 4'h2, 0, 0, IRQ ? 32'h0004_0155 : 32'h0000_0155, "qcfg0_no_be"));
        vecs.push_back(mk(1, 4'h4, 32'hFFFF_FFFF, 4'hF, 0, ""));
        vecs.push_back(mk(0, 4'h4, 0, 0, 32'h0, "qcfg2_unmapped"));
        vecs.push_back(mk(0, 4'h8, 0, 0, 32'h0, "qcnt2_unmapped"));
        vecs.push_back(mk(0, 4'hB, 0, 0, 32'h0, "addr_b"));
        vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0, "addr_f"));
        vecs.push_back(mk(1, 4'hA, 32'h3, 4'hF, 0, ""));
        vecs.push_back(mk(0, 4'hA, 0, 0, IRQ ? 32'h3 : 32'h0, "imask"));
        vecs.push_back(mk(1, 4'hA, 32'h0, 4'hF, 0, ""));
        vecs.push_back(mk(1, 4'h0, 32'hFF, 4'hF, 0, ""));
        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h3, "ctrl_nch_bits"));
        vecs.push_back(mk(1, 4'h0, 32'h0, 4'b0010, 0, ""));
        vecs.push_back(mk(0, 4'h0, 0, 0, 32'h3, "ctrl_be_masked"));

        repeat (3) @(negedge app_clk);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge app_clk);

        foreach (vecs[i]) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wd, vecs[i].be);
            else            rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        chk("qbase_out", 32'(qbase_addr), {12'h0, 10'h0A5, 10'h155});

        // occupancy counting on queue 0, then saturation and overflow
        repeat (3) pulse(2'b01, 2'b00);
        rd_chk(4'h6, 32'h3, "qcnt0_three");
        chk("qempty0_clear", 32'(q_empty), 32'h2);
        repeat (13) pulse(2'b01, 2'b00);
        chk("qcnt0_sat", 32'(qcnt[QDW-1:0]), 32'hF);
        chk("qfull0", 32'(q_full), 32'h1);
        rd_chk(4'h1, 32'h1, "stat_ovf0");
        wr(4'h1, 32'h1, 4'h1);
        rd_chk(4'h1, 32'h0, "stat_ovf0_w1c");

        // simultaneous inc/dec on queue 1, then underflow
        repeat (5) pulse(2'b10, 2'b00);
        pulse(2'b10, 2'b10);
        rd_chk(4'h7, 32'h5, "qcnt1_incdec");
        rd_chk(4'h1, 32'h0, "stat_incdec_none");
        repeat (5) pulse(2'b00, 2'b10);
        chk("qempty1", 32'(q_empty[1]), 32'h1);
        pulse(2'b00, 2'b10);
        rd_chk(4'h1, 32'h200, "stat_unf1");
        rd_chk(4'h7, 32'h0, "qcnt1_hold0");

        // W1C and an underflow event on the same edge: the set must survive
        @(negedge app_clk);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'h1; reg_wdata = 32'h200; reg_be = 4'b0010;
        qcnt_dec = 2'b10;
        @(negedge app_clk);
        reg_cs = 1'b0; qcnt_dec = '0;
        chk("setwins_ack", {31'b0, reg_ack}, 32'h1);
        rd_chk(4'h1, 32'h200, "stat_set_wins");
        wr(4'h1, 32'h200, 4'b0010);
        rd_chk(4'h1, 32'h0, "stat_unf_w1c");

        // disabling queue 0 zeroes its count; disabled queue ignores events
        wr(4'h0, 32'h2, 4'h1);
        chk("qcnt0_disabled", 32'(qcnt[QDW-1:0]), 32'h0);
        pulse(2'b01, 2'b00);
        pulse(2'b00, 2'b01);
        chk("qcnt0_ignored", 32'(qcnt[QDW-1:0]), 32'h0);
        rd_chk(4'h1, 32'h0, "stat_disabled");

        // threshold interrupt on queue 0 (threshold 4 already in QCFG0 when implemented)
        wr(4'h0, 32'h3, 4'h1);
        wr(4'hA, 32'h1, 4'h1);
        repeat (4) pulse(2'b01, 2'b00);
        chk("thr_cnt4", 32'(qcnt[QDW-1:0]), 32'h4);
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge app_clk);
        chk("irq_asserted", {31'b0, irq}, {31'b0, IRQ});
        pulse(2'b00, 2'b01);
        chk("irq_still_set", {31'b0, irq}, {31'b0, IRQ});
        @(negedge app_clk);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        // reset during an in-flight CTRL write
        @(negedge app_clk);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'h0; reg_wdata = 32'h3; reg_be = 4'hF;
        #2 reset_n = 1'b0;
        @(negedge app_clk);
        reg_cs = 1'b0;
        chk_reset_outputs("midrst");
        @(negedge app_clk);
        reset_n = 1'b1;
        @(negedge app_clk);
        chk("midrst_noack", {31'b0, reg_ack}, 32'h0);
        rd_chk(4'h0, 32'h0, "ctrl_after_rst");
        rd_chk(4'h2, 32'h0, "qcfg0_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
